// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, FSM encoding, opcode field.
package fetch_unit_pkg;

    localparam int unsigned AW_DEF       = 10;
    localparam int unsigned IW_DEF       = 16;
    localparam int unsigned RESET_PC_DEF = 0;

    // Branch offset width and opcode field position within an instruction word
    localparam int unsigned BR_W    = 6;
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_target.sv
// Next-PC selection: jump has priority over branch, otherwise sequential; all wrap modulo 2^AW.
module pc_target
    import fetch_unit_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic [AW-1:0]   pc_i,
    input  logic [AW-1:0]   instr_pc_i,
    input  logic            jmp_en_i,
    input  logic [AW-1:0]   jmp_dir_i,
    input  logic            br_en_i,
    input  logic [BR_W-1:0] br_dir_i,
    output logic [AW-1:0]   next_pc_c_o,
    output logic            redirect_c_o
);

    logic [AW-1:0] br_off_c;

    // Priority mux of sequential, jump and PC-relative branch targets
    always_comb begin
        br_off_c     = {{(AW-BR_W){br_dir_i[BR_W-1]}}, br_dir_i};
        redirect_c_o = jmp_en_i | br_en_i;
        next_pc_c_o  = pc_i + AW'(1);
        if (jmp_en_i) begin
            next_pc_c_o = jmp_dir_i;
        end else if (br_en_i) begin
            next_pc_c_o = instr_pc_i + br_off_c;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch to instruction memory, valid/ready output, redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned   AW       = AW_DEF,
    parameter int unsigned   IW       = IW_DEF,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_data,
    output logic [IW-1:0]   instr,
    output logic [AW-1:0]   instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            jmp_en,
    input  logic [AW-1:0]   jmp_dir,
    input  logic            br_en,
    input  logic [BR_W-1:0] br_dir
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [AW-1:0] instr_pc_q, instr_pc_d;
    logic          instr_valid_q;
    logic          imem_req_q;

    logic [AW-1:0] next_pc_c;
    logic          redirect_c;

    pc_target #(
        .AW (AW)
    ) u_pc_target (
        .pc_i         (pc_q),
        .instr_pc_i   (instr_pc_q),
        .jmp_en_i     (jmp_en),
        .jmp_dir_i    (jmp_dir),
        .br_en_i      (br_en),
        .br_dir_i     (br_dir),
        .next_pc_c_o  (next_pc_c),
        .redirect_c_o (redirect_c)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect always abandons the current fetch or held instruction
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    state_d = redirect_c ? ST_REQ : ST_HOLD;
                end else if (redirect_c) begin
                    state_d = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (redirect_c || instr_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; req_addr only moves when a new request is launched
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect_c) begin
                    pc_d = next_pc_c;
                end
                req_addr_d = pc_d;
            end
            ST_REQ: begin
                if (imem_ack && !redirect_c) begin
                    instr_d    = imem_data;
                    instr_pc_d = pc_q;
                    pc_d       = next_pc_c;
                end else if (redirect_c) begin
                    pc_d = next_pc_c;
                    if (imem_ack) begin
                        req_addr_d = next_pc_c;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_c) begin
                    pc_d       = next_pc_c;
                    req_addr_d = next_pc_c;
                end else if (instr_ready) begin
                    req_addr_d = pc_q;
                end
            end
            ST_DROP: begin
                if (redirect_c) begin
                    pc_d = next_pc_c;
                end
                // Stale response discarded; relaunch at the newest target
                if (imem_ack) begin
                    req_addr_d = pc_d;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= (state_d == ST_HOLD);
            imem_req_q    <= (state_d == ST_REQ) || (state_d == ST_DROP);
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = req_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule
